// File: rtl/pa_top_if.sv
// pa_top_if: vertex-store read port, rasterizer handshake and status of the primitive
// assembly stage. Handshake: a triangle transfers on a clock edge where pa_rast_valid and
// rast_pa_ready are both high; once pa_rast_valid rises, it and every pa_rast_* signal
// stay stable until that edge, and ready seen while valid is low does nothing.
interface pa_top_if #(
    parameter int FIXED_WIDTH = 16,
    parameter int INDEX_BIT   = 4
);
    logic                     vs_pa_valid;
    logic [INDEX_BIT-1:0]     num_vertex_in;
    logic [INDEX_BIT-1:0]     pa_2d_vertex_index;
    logic [FIXED_WIDTH-1:0]   vertex_2d_pa_data;
    logic                     pa_rast_valid;
    logic                     rast_pa_ready;
    logic [6*FIXED_WIDTH-1:0] pa_rast_tri;
    logic [4*FIXED_WIDTH-1:0] pa_rast_bbox;
    logic [2*FIXED_WIDTH+2:0] pa_rast_area;
    logic                     pa_busy;
    logic                     pa_done;
    logic [2:0]               pa_state;

    // Primitive assembly side.
    modport master (
        input  vs_pa_valid, num_vertex_in, vertex_2d_pa_data, rast_pa_ready,
        output pa_2d_vertex_index, pa_rast_valid, pa_rast_tri, pa_rast_bbox,
        output pa_rast_area, pa_busy, pa_done, pa_state
    );

    // Vertex shader / vertex store / rasterizer side.
    modport slave (
        output vs_pa_valid, num_vertex_in, vertex_2d_pa_data, rast_pa_ready,
        input  pa_2d_vertex_index, pa_rast_valid, pa_rast_tri, pa_rast_bbox,
        input  pa_rast_area, pa_busy, pa_done, pa_state
    );
endinterface

// File: rtl/pa_top.sv
// pa_top: reads vertices three at a time from the 2D vertex store, computes the signed
// doubled area and a screen-clamped bounding box, culls back-facing, degenerate and
// off-screen triangles, and offers the survivors to the rasterizer. pa_state mirrors the
// FSM state for observation.
module pa_top #(
    parameter int FIXED_WIDTH = 16,
    parameter int INDEX_BIT   = 4,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic     clk,
    input  logic     reset,
    pa_top_if.master bus
);
    localparam int FW = FIXED_WIDTH;
    localparam int DW = FW + 1;
    localparam int PW = 2 * FW + 2;
    localparam int AW = 2 * FW + 3;
    localparam logic signed [FW-1:0] ZERO   = '0;
    localparam logic signed [FW-1:0] X_LAST = FW'(SCREEN_W - 1);
    localparam logic signed [FW-1:0] Y_LAST = FW'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SETUP = 3'd2,
        EMIT  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state;
    logic [2:0]           k;
    logic [INDEX_BIT-1:0] base;
    logic [INDEX_BIT-1:0] num_vertex_reg;
    logic signed [FW-1:0] coord [6];

    logic signed [FW-1:0] x0, y0, x1, y1, x2, y2;
    logic signed [DW-1:0] dx1, dy1, dx2, dy2;
    logic signed [PW-1:0] prod_a, prod_b;
    logic signed [AW-1:0] area;
    logic signed [FW-1:0] rmin_x, rmax_x, rmin_y, rmax_y;
    logic signed [FW-1:0] min_x, max_x, min_y, max_y;
    logic                 cull;
    logic [INDEX_BIT-1:0] next_base;
    logic                 more_tris;

    assign x0 = coord[0];
    assign y0 = coord[1];
    assign x1 = coord[2];
    assign y1 = coord[3];
    assign x2 = coord[4];
    assign y2 = coord[5];

    assign next_base = base + INDEX_BIT'(3);
    // Another full triangle fits when the new base plus three vertices stays within the count.
    assign more_tris = ({1'b0, next_base} + (INDEX_BIT + 1)'(3)) <= {1'b0, num_vertex_reg};

    assign bus.pa_state = state;

    // Signed doubled area, raw and clamped bounding box, and the cull decision.
    always_comb begin
        dx1    = DW'(x1) - DW'(x0);
        dy1    = DW'(y1) - DW'(y0);
        dx2    = DW'(x2) - DW'(x0);
        dy2    = DW'(y2) - DW'(y0);
        prod_a = PW'(dx1) * PW'(dy2);
        prod_b = PW'(dx2) * PW'(dy1);
        area   = AW'(prod_a) - AW'(prod_b);

        rmin_x = (x0 < x1) ? x0 : x1;
        rmin_x = (x2 < rmin_x) ? x2 : rmin_x;
        rmax_x = (x0 > x1) ? x0 : x1;
        rmax_x = (x2 > rmax_x) ? x2 : rmax_x;
        rmin_y = (y0 < y1) ? y0 : y1;
        rmin_y = (y2 < rmin_y) ? y2 : rmin_y;
        rmax_y = (y0 > y1) ? y0 : y1;
        rmax_y = (y2 > rmax_y) ? y2 : rmax_y;

        min_x = (rmin_x < ZERO) ? ZERO : rmin_x;
        max_x = (rmax_x > X_LAST) ? X_LAST : rmax_x;
        min_y = (rmin_y < ZERO) ? ZERO : rmin_y;
        max_y = (rmax_y > Y_LAST) ? Y_LAST : rmax_y;

        // Clockwise (negative) and zero-area triangles are dropped, as is anything fully off-screen.
        cull = area[AW-1] || (area == '0)
            || (rmax_x < ZERO) || (rmin_x > X_LAST)
            || (rmax_y < ZERO) || (rmin_y > Y_LAST);
    end

    // Batch FSM with registered address, handshake, triangle and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            k                      <= '0;
            base                   <= '0;
            num_vertex_reg         <= '0;
            for (int i = 0; i < 6; i++) coord[i] <= '0;
            bus.pa_2d_vertex_index <= '0;
            bus.pa_rast_valid      <= 1'b0;
            bus.pa_rast_tri        <= '0;
            bus.pa_rast_bbox       <= '0;
            bus.pa_rast_area       <= '0;
            bus.pa_busy            <= 1'b0;
            bus.pa_done            <= 1'b0;
        end else begin
            bus.pa_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.vs_pa_valid) begin
                        num_vertex_reg <= bus.num_vertex_in;
                        base           <= '0;
                        bus.pa_busy    <= 1'b1;
                        if (bus.num_vertex_in >= INDEX_BIT'(3)) begin
                            state                  <= FETCH;
                            k                      <= '0;
                            bus.pa_2d_vertex_index <= '0;
                        end else begin
                            state       <= DONE;
                            bus.pa_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Read data lags the address by one cycle, so capture trails the counter.
                    if (k != 3'd0) coord[k - 3'd1] <= bus.vertex_2d_pa_data;
                    if (k < 3'd5) begin
                        bus.pa_2d_vertex_index <= (base << 1) + INDEX_BIT'(k) + INDEX_BIT'(1);
                    end
                    if (k == 3'd6) begin
                        state <= SETUP;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                SETUP: begin
                    bus.pa_rast_tri  <= {x0, y0, x1, y1, x2, y2};
                    bus.pa_rast_bbox <= {min_x, min_y, max_x, max_y};
                    bus.pa_rast_area <= area;
                    if (cull) begin
                        state <= NEXT;
                    end else begin
                        state             <= EMIT;
                        bus.pa_rast_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.rast_pa_ready) begin
                        bus.pa_rast_valid <= 1'b0;
                        state             <= NEXT;
                    end
                end
                NEXT: begin
                    base <= next_base;
                    if (more_tris) begin
                        state                  <= FETCH;
                        k                      <= '0;
                        bus.pa_2d_vertex_index <= next_base << 1;
                    end else begin
                        state       <= DONE;
                        bus.pa_done <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.pa_busy <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.pa_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pa_top.sv
// tb_pa_top: directed and randomized batches for pa_top; expected transfers, cycle counts and
// address usage come from a triangle-level reference model kept in this file.
module tb_pa_top;
    localparam int FW = 16;
    localparam int IB = 4;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int AW = 2 * FW + 3;
    localparam int XW = 10 * FW + AW;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    pa_top_if #(.FIXED_WIDTH(FW), .INDEX_BIT(IB)) bus ();

    pa_top #(.FIXED_WIDTH(FW), .INDEX_BIT(IB), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 2D vertex store: synchronous read, data one cycle after the address.
    logic [FW-1:0] mem [16];
    always @(posedge clk) bus.vertex_2d_pa_data <= mem[bus.pa_2d_vertex_index];

    // ---------------- scoreboard state ----------------
    logic [XW-1:0] exp_q[$];
    logic [XW-1:0] cur, held, last_xfer, exp_item;
    bit            held_v = 1'b0;
    int            n_done = 0, done_cyc = 0, first_valid_cyc = -1, n_xfer = 0, n_stall = 0;
    int            addr_changes = 0, addr_max = -1, c0 = 0;
    bit            addr_seen [16];
    logic [IB-1:0] prev_idx = '0;

    assign cur = {bus.pa_rast_tri, bus.pa_rast_bbox, bus.pa_rast_area};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic void tri_eval(input int x0, input int y0, input int x1, input int y1,
                                     input int x2, input int y2, output longint area,
                                     output int mnx, output int mny, output int mxx,
                                     output int mxy, output bit cl);
        int rnx, rxx, rny, rxy;
        area = longint'(x1 - x0) * longint'(y2 - y0) - longint'(x2 - x0) * longint'(y1 - y0);
        rnx = min3(x0, x1, x2);
        rxx = max3(x0, x1, x2);
        rny = min3(y0, y1, y2);
        rxy = max3(y0, y1, y2);
        mnx = (rnx < 0) ? 0 : rnx;
        mny = (rny < 0) ? 0 : rny;
        mxx = (rxx > SW - 1) ? SW - 1 : rxx;
        mxy = (rxy > SH - 1) ? SH - 1 : rxy;
        cl  = (area <= 0) || (rxx < 0) || (rnx > SW - 1) || (rxy < 0) || (rny > SH - 1);
    endfunction

    // Queues every surviving triangle of the batch; lat is the pa_done cycle offset from the
    // vs_pa_valid cycle when the rasterizer never stalls.
    function automatic void model_batch(input int nv, output int n_emit, output int lat);
        longint a;
        int     mnx, mny, mxx, mxy;
        bit     cl;
        int     v [6];
        n_emit = 0;
        lat    = 1;
        for (int t = 0; t + 3 <= nv; t += 3) begin
            for (int i = 0; i < 6; i++) v[i] = int'($signed(mem[2 * t + i]));
            tri_eval(v[0], v[1], v[2], v[3], v[4], v[5], a, mnx, mny, mxx, mxy, cl);
            if (cl) begin
                lat += 9;
            end else begin
                lat += 10;
                n_emit++;
                exp_q.push_back({FW'(v[0]), FW'(v[1]), FW'(v[2]), FW'(v[3]), FW'(v[4]), FW'(v[5]),
                                 FW'(mnx), FW'(mny), FW'(mxx), FW'(mxy), AW'(a)});
            end
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset) begin
            held_v   = 1'b0;
            prev_idx = bus.pa_2d_vertex_index;
        end else begin
            if (bus.pa_rast_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (held_v) check("hold_stable", 256'(cur), 256'(held));
                if (bus.rast_pa_ready) begin
                    n_xfer++;
                    last_xfer = cur;
                    held_v    = 1'b0;
                    check("xfer_expected", 256'(exp_q.size() != 0), 256'(1));
                    if (exp_q.size() != 0) begin
                        exp_item = exp_q.pop_front();
                        check("xfer_data", 256'(cur), 256'(exp_item));
                    end
                end else begin
                    n_stall++;
                    held   = cur;
                    held_v = 1'b1;
                end
            end else begin
                if (held_v) check("valid_held", 256'(bus.pa_rast_valid), 256'(1));
                held_v = 1'b0;
            end
            if (bus.pa_done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_with_done", 256'(bus.pa_busy), 256'(1));
            end
            if (bus.pa_2d_vertex_index != prev_idx) addr_changes++;
            prev_idx = bus.pa_2d_vertex_index;
            if (bus.pa_busy) begin
                addr_seen[bus.pa_2d_vertex_index] = 1'b1;
                if (int'(bus.pa_2d_vertex_index) > addr_max) addr_max = int'(bus.pa_2d_vertex_index);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_vertex(input int v, input int x, input int y);
        mem[2 * v]     = FW'(x);
        mem[2 * v + 1] = FW'(y);
    endtask

    task automatic set_tri(input int v, input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        set_vertex(v, x0, y0);
        set_vertex(v + 1, x1, y1);
        set_vertex(v + 2, x2, y2);
    endtask

    // mode 0: ready high; mode 1: random ready; mode 2: ready low for `stall` valid cycles.
    task automatic run_batch(input int nv, input int mode, input int stall, input bit repulse);
        int n_emit, lat, n_done0, stall_left, seen_cnt;
        model_batch(nv, n_emit, lat);
        n_done0         = n_done;
        n_xfer          = 0;
        n_stall         = 0;
        first_valid_cyc = -1;
        addr_changes    = 0;
        addr_max        = -1;
        for (int i = 0; i < 16; i++) addr_seen[i] = 1'b0;
        stall_left = stall;
        @(posedge clk);
        #1;
        bus.vs_pa_valid   = 1'b1;
        bus.num_vertex_in = IB'(nv);
        bus.rast_pa_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        c0 = cyc;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.vs_pa_valid   = repulse && (i == 12);
            bus.num_vertex_in = (repulse && i == 12) ? IB'(3) : IB'(nv);
            if (mode == 1) begin
                bus.rast_pa_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && bus.pa_rast_valid && stall_left > 0) begin
                bus.rast_pa_ready = 1'b0;
                stall_left--;
            end else begin
                bus.rast_pa_ready = 1'b1;
            end
            if (n_done != n_done0) break;
        end
        check("done_within_budget", 256'(n_done != n_done0), 256'(1));
        @(negedge clk);
        #1;
        check("done_pulses", 256'(n_done - n_done0), 256'(1));
        check("busy_after_done", 256'(bus.pa_busy), 256'(0));
        check("xfer_count", 256'(n_xfer), 256'(n_emit));
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        check("done_latency", 256'(done_cyc - c0), 256'(lat + n_stall));
        if (nv < 3) begin
            check("no_addr_activity", 256'(addr_changes), 256'(0));
        end else begin
            seen_cnt = 0;
            for (int i = 0; i < 16; i++) seen_cnt += int'(addr_seen[i]);
            check("addr_in_range", 256'(addr_max < 6 * (nv / 3)), 256'(1));
            check("addr_count", 256'(seen_cnt), 256'(6 * (nv / 3)));
        end
        if (n_done == n_done0) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
        exp_q.delete();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        longint a;
        int     mnx, mny, mxx, mxy, n_emit, lat, n_done0, nv;
        bit     cl;

        reset             = 1'b1;
        bus.vs_pa_valid   = 1'b0;
        bus.num_vertex_in = '0;
        bus.rast_pa_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 256'(bus.pa_rast_valid), 256'(0));
        check("reset_busy", 256'(bus.pa_busy), 256'(0));
        check("reset_done", 256'(bus.pa_done), 256'(0));
        check("reset_outputs", 256'({bus.pa_2d_vertex_index, bus.pa_rast_tri, bus.pa_rast_bbox,
                                     bus.pa_rast_area}), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Hand-computed values that pin the model.
        tri_eval(10, 10, 50, 10, 10, 40, a, mnx, mny, mxx, mxy, cl);
        check("model_area_ccw", 256'(a), 256'(1200));
        check("model_bbox_ccw", 256'({mnx, mny, mxx, mxy}), 256'({32'd10, 32'd10, 32'd50, 32'd40}));
        check("model_cull_ccw", 256'(cl), 256'(0));
        tri_eval(10, 10, 10, 40, 50, 10, a, mnx, mny, mxx, mxy, cl);
        check("model_area_cw", 256'(a), 256'(-1200));
        check("model_cull_cw", 256'(cl), 256'(1));
        tri_eval(-20, -5, 200, 30, 30, 150, a, mnx, mny, mxx, mxy, cl);
        check("model_area_big", 256'(a), 256'(32350));
        check("model_bbox_big", 256'({mnx, mny, mxx, mxy}), 256'({32'd0, 32'd0, 32'd159, 32'd119}));
        tri_eval(170, 10, 200, 10, 170, 50, a, mnx, mny, mxx, mxy, cl);
        check("model_cull_offscreen", 256'(cl), 256'(1));
        tri_eval(0, 0, 5, 5, 10, 10, a, mnx, mny, mxx, mxy, cl);
        check("model_area_degen", 256'(a), 256'(0));

        // One front-facing triangle.
        set_tri(0, 10, 10, 50, 10, 10, 40);
        run_batch(3, 0, 0, 1'b0);
        check("t1_first_valid", 256'(first_valid_cyc - c0), 256'(9));
        check("t1_done_cycle", 256'(done_cyc - c0), 256'(11));
        check("t1_area", 256'(last_xfer[AW-1:0]), 256'(1200));
        check("t1_bbox", 256'(last_xfer[AW +: 4 * FW]), 256'({16'd10, 16'd10, 16'd50, 16'd40}));

        // Clockwise: culled.
        set_tri(0, 10, 10, 10, 40, 50, 10);
        run_batch(3, 0, 0, 1'b0);
        check("t2_done_cycle", 256'(done_cyc - c0), 256'(10));

        // Partly off-screen: emitted with clamped box.
        set_tri(0, -20, -5, 200, 30, 30, 150);
        run_batch(3, 0, 0, 1'b0);
        check("t3_bbox", 256'(last_xfer[AW +: 4 * FW]), 256'({16'd0, 16'd0, 16'd159, 16'd119}));
        check("t3_area", 256'(last_xfer[AW-1:0]), 256'(32350));

        // Fully right of the screen, then degenerate.
        set_tri(0, 170, 10, 200, 10, 170, 50);
        run_batch(3, 0, 0, 1'b0);
        set_tri(0, 0, 0, 5, 5, 10, 10);
        run_batch(3, 1, 0, 1'b0);

        // Seven vertices, two emitted triangles, first one stalled, re-pulse while busy.
        set_tri(0, 10, 10, 50, 10, 10, 40);
        set_tri(3, -20, -5, 200, 30, 30, 150);
        set_vertex(6, 1, 1);
        run_batch(7, 2, 5, 1'b1);
        check("t5_stalls", 256'(n_stall), 256'(5));
        check("t5_vertex6_unread", 256'({addr_seen[12], addr_seen[13]}), 256'(0));

        // Empty batch.
        run_batch(2, 0, 0, 1'b0);
        check("t6_done_cycle", 256'(done_cyc - c0), 256'(1));

        // Randomized batches.
        for (int b = 0; b < 24; b++) begin
            nv = $urandom_range(0, 8);
            for (int v = 0; v < 8; v++) begin
                set_vertex(v, int'($urandom_range(0, 260)) - 50, int'($urandom_range(0, 200)) - 40);
            end
            run_batch(nv, b % 2, 0, 1'b0);
        end

        // Reset while a triangle waits in EMIT.
        set_tri(0, 10, 10, 50, 10, 10, 40);
        model_batch(3, n_emit, lat);
        n_done0 = n_done;
        @(posedge clk);
        #1;
        bus.vs_pa_valid   = 1'b1;
        bus.num_vertex_in = IB'(3);
        bus.rast_pa_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.vs_pa_valid = 1'b0;
        for (int i = 0; i < 40 && !bus.pa_rast_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_emit_reached", 256'(bus.pa_rast_valid), 256'(1));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid_drop", 256'(bus.pa_rast_valid), 256'(0));
        check("rst_busy_drop", 256'(bus.pa_busy), 256'(0));
        reset             = 1'b0;
        bus.rast_pa_ready = 1'b1;
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("rst_no_done", 256'(n_done - n_done0), 256'(0));

        // Recovery after reset.
        run_batch(3, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pa_top.md
# pa_top

Primitive assembly stage directly downstream of the vertex shader. After the vertex shader has filled the 2D (screen-space) vertex store, this block reads vertices back three at a time and forms triangles. For each triangle it computes the signed area and a screen-clamped bounding box, culls back-facing, degenerate and fully off-screen triangles, and hands surviving triangles to the rasterizer over a valid/ready handshake.

## Interface

**Parameters**
- `FIXED_WIDTH`, default 16: width of one coordinate word (signed integer pixels).
- `INDEX_BIT`, default 4: 2D vertex store address width and vertex-count width.
- `SCREEN_W`, default 160: screen width in pixels.
- `SCREEN_H`, default 120: screen height in pixels.

**Ports**
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `vs_pa_valid`, in, 1: one-cycle pulse; the 2D vertex store is complete.
- `num_vertex_in`, in, INDEX_BIT: number of vertices in the store; sampled with `vs_pa_valid`.
- `pa_2d_vertex_index`, out, INDEX_BIT: read address into the 2D vertex store.
- `vertex_2d_pa_data`, in, FIXED_WIDTH: read data, valid one cycle after the address.
- `pa_rast_valid`, out, 1: triangle output valid.
- `rast_pa_ready`, in, 1: rasterizer accepts the triangle.
- `pa_rast_tri`, out, 6*FIXED_WIDTH: {x0,y0,x1,y1,x2,y2}, with x0 in the MSBs.
- `pa_rast_bbox`, out, 4*FIXED_WIDTH: {min_x,min_y,max_x,max_y}, with min_x in the MSBs.
- `pa_rast_area`, out, 2*FIXED_WIDTH+3: signed doubled area.
- `pa_busy`, out, 1: high in every state except IDLE.
- `pa_done`, out, 1: one-cycle pulse when the batch is finished.

## Operation

**Store layout**
- Vertex v has x at address 2v and y at address 2v+1.
- Maximum vertex count is 2^(INDEX_BIT-1).

**Batch**
- Triangle count is floor(num_vertex/3); leftover vertices are ignored.
- `num_vertex_reg` is captured when `vs_pa_valid` is seen in IDLE.
- `vs_pa_valid` in any other state is ignored.

**State machine**
- IDLE -> FETCH when `vs_pa_valid` is high and num_vertex >= 3.
- IDLE -> DONE when `vs_pa_valid` is high and num_vertex < 3.
- FETCH, 7 cycles (counter k = 0..6):
  - For k <= 5, drive address 2*base + k.
  - For k >= 1, capture data into coordinate k-1.
  - Then go to SETUP.
- SETUP, 1 cycle: register area, bbox and the cull flag.
  - Go to EMIT if not culled, else go to NEXT.
- EMIT: hold `pa_rast_valid` high with stable outputs until `rast_pa_ready` is high. The transfer completes on that cycle; then go to NEXT.
- NEXT, 1 cycle: base += 3.
  - Go to FETCH if base+3 (new base) + 3 <= num_vertex, else go to DONE.
- DONE, 1 cycle: `pa_done` = 1, then go to IDLE.

**Arithmetic** (all signed)
- area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
- Differences are FIXED_WIDTH+1 bits, products are 2*FIXED_WIDTH+2 bits, the result is 2*FIXED_WIDTH+3 bits. No overflow is possible.
- Raw bbox: rmin/rmax over the three vertices, per axis.
- Clamped bbox:
  - min_x = max(0, rmin_x); max_x = min(SCREEN_W-1, rmax_x).
  - min_y and max_y use the same rule with SCREEN_H.
- Cull when any of the following holds:
  - area <= 0 (counter-clockwise is front-facing);
  - rmax_x < 0 or rmin_x > SCREEN_W-1;
  - rmax_y < 0 or rmin_y > SCREEN_H-1.

## Timing

**Reset values**
- State is IDLE.
- `pa_rast_valid`, `pa_busy`, `pa_done` are 0.
- `pa_2d_vertex_index`, `pa_rast_tri`, `pa_rast_bbox`, `pa_rast_area` are 0.
- base and num_vertex_reg are 0.

**Latency**
- `vs_pa_valid` is seen at cycle c.
- FETCH occupies c+1..c+7, SETUP is c+8, and the first `pa_rast_valid` is at c+9.
- Per triangle with `rast_pa_ready` tied high: 7 + 1 + 1 + 1 = 10 cycles. A culled triangle takes 9 cycles.

**Empty batch**
- With num_vertex < 3, `pa_done` pulses at c+1 and no address or valid activity occurs.

**Handshake**
- While `pa_rast_valid` is high and `rast_pa_ready` is low, all `pa_rast_*` outputs are frozen.
- A ready that arrives while valid is low has no effect.

**Address port**
- `pa_2d_vertex_index` outside FETCH holds its last value; the store ignores it.

**Reset mid-operation**
- Reset returns the block to IDLE next cycle.
- `pa_rast_valid` drops.
- No `pa_done` pulse is produced.

## Test plan

1. num_vertex=3, vertices (10,10),(50,10),(10,40), ready high.
   - One triangle: area=1200, bbox (10,10,50,40), valid at c+9, `pa_done` at c+11.
2. Vertices (10,10),(10,40),(50,10) (clockwise).
   - area=-1200, so culled.
   - No valid; `pa_done` at c+10.
3. Vertices (-20,-5),(200,30),(30,150).
   - area=32350, bbox clamped to (0,0,159,119), emitted.
4. Vertices (170,10),(200,10),(170,50).
   - area=1200 but rmin_x=170>159, so culled.
   - Also check degenerate (0,0),(5,5),(10,10): area=0, culled.
5. num_vertex=7 holding two valid triangles, `rast_pa_ready` low for 5 cycles on the first.
   - Outputs stay stable while ready is low.
   - Exactly 2 transfers occur; vertex 6 is never addressed.
   - Re-pulsing `vs_pa_valid` while busy is ignored.
6. num_vertex=2 -> `pa_done` at c+1 with no reads.
   - Assert reset during EMIT -> valid=0 and IDLE next cycle, with no `pa_done`.
